// File: rtl/alu_exec_unit_if.sv
// Request/write-back bundle between the register file read ports and the ALU execute stage.
// The master drives an issue request; the slave returns busy and the write-back strobe.
interface alu_exec_unit_if #(
  parameter int WIDTH = 5,
  parameter int AW    = 2
) ();
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [AW-1:0]    dst;
  logic             busy;
  logic             wb_en;
  logic [AW-1:0]    wb_addr;
  logic [WIDTH-1:0] wb_data;
  logic             zero;
  logic             carry;
  logic             div_by_zero;

  modport master (
    output start, op, a, b, dst,
    input  busy, wb_en, wb_addr, wb_data, zero, carry, div_by_zero
  );

  modport slave (
    input  start, op, a, b, dst,
    output busy, wb_en, wb_addr, wb_data, zero, carry, div_by_zero
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute stage: single-cycle ADD/SUB/AND/OR/XOR/SHL, iterative shift-add MUL and
// restoring DIV, with a one-cycle write-back into the register file.
module alu_exec_unit #(
  parameter int WIDTH = 5,
  parameter int AW    = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_exec_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               op_div_q, op_div_d;
  logic [AW-1:0]      dst_q, dst_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   wb_data_q, wb_data_d;
  logic [AW-1:0]      wb_addr_q, wb_addr_d;
  logic               zero_q, zero_d;
  logic               carry_q, carry_d;
  logic               dbz_q, dbz_d;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [WIDTH+7:0]   shl_full;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_carry;

  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     rem_shift;
  logic               rem_ge;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   quo_next;

  // Single-cycle ops work straight off the read-port values on the issue edge.
  always_comb begin
    sum       = {1'b0, bus.a} + {1'b0, bus.b};
    diff      = {1'b0, bus.a} - {1'b0, bus.b};
    shl_full  = {8'b0, bus.a} << bus.b[2:0];
    alu_res   = '0;
    alu_carry = 1'b0;
    case (bus.op)
      3'b000: begin
        alu_res   = sum[WIDTH-1:0];
        alu_carry = sum[WIDTH];
      end
      3'b001: begin
        alu_res   = diff[WIDTH-1:0];
        alu_carry = diff[WIDTH];
      end
      3'b010: alu_res = bus.a & bus.b;
      3'b011: alu_res = bus.a | bus.b;
      3'b100: alu_res = bus.a ^ bus.b;
      3'b101: begin
        alu_res   = shl_full[WIDTH-1:0];
        alu_carry = |shl_full[WIDTH+7:WIDTH];
      end
      default: begin
        alu_res   = '0;
        alu_carry = 1'b0;
      end
    endcase
  end

  // One iteration step: MUL consumes b LSB-first, DIV consumes a MSB-first.
  // With b==0 every restoring compare succeeds, so the quotient saturates to all ones.
  always_comb begin
    mul_next  = acc_q + (b_q[0] ? ({{WIDTH{1'b0}}, a_q} << cnt_q) : '0);
    rem_shift = {rem_q, a_q[WIDTH-1]};
    rem_ge    = (rem_shift >= {1'b0, b_q});
    rem_next  = rem_ge ? (rem_shift[WIDTH-1:0] - b_q) : rem_shift[WIDTH-1:0];
    quo_next  = {acc_q[WIDTH-2:0], rem_ge};
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    op_div_d  = op_div_q;
    dst_d     = dst_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    wb_data_d = wb_data_q;
    wb_addr_d = wb_addr_q;
    zero_d    = zero_q;
    carry_d   = carry_q;
    dbz_d     = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d      = bus.a;
          b_d      = bus.b;
          op_div_d = bus.op[0];
          dst_d    = bus.dst;
          if (bus.op[2:1] == 2'b11) begin
            state_d = S_ITER;
            cnt_d   = '0;
            acc_d   = '0;
            rem_d   = '0;
          end else begin
            state_d   = S_WB;
            wb_data_d = alu_res;
            wb_addr_d = bus.dst;
            zero_d    = (alu_res == '0);
            carry_d   = alu_carry;
            dbz_d     = 1'b0;
          end
        end
      end
      S_ITER: begin
        cnt_d = cnt_q + CW'(1);
        if (op_div_q) begin
          a_d   = a_q << 1;
          rem_d = rem_next;
          acc_d = {{WIDTH{1'b0}}, quo_next};
        end else begin
          b_d   = b_q >> 1;
          acc_d = mul_next;
        end
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d   = S_WB;
          wb_addr_d = dst_q;
          if (op_div_q) begin
            wb_data_d = quo_next;
            zero_d    = (quo_next == '0);
            carry_d   = 1'b0;
            dbz_d     = (b_q == '0);
          end else begin
            wb_data_d = mul_next[WIDTH-1:0];
            zero_d    = (mul_next[WIDTH-1:0] == '0);
            carry_d   = |mul_next[2*WIDTH-1:WIDTH];
            dbz_d     = 1'b0;
          end
        end
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      op_div_q  <= 1'b0;
      dst_q     <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      wb_data_q <= '0;
      wb_addr_q <= '0;
      zero_q    <= 1'b0;
      carry_q   <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_div_q  <= op_div_d;
      dst_q     <= dst_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      wb_data_q <= wb_data_d;
      wb_addr_q <= wb_addr_d;
      zero_q    <= zero_d;
      carry_q   <= carry_d;
      dbz_q     <= dbz_d;
    end
  end

  assign bus.busy        = (state_q != S_IDLE);
  assign bus.wb_en       = (state_q == S_WB);
  assign bus.wb_addr     = wb_addr_q;
  assign bus.wb_data     = wb_data_q;
  assign bus.zero        = zero_q;
  assign bus.carry       = carry_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: arithmetic reference model plus a per-cycle
// compare process, directed literal cases and randomized traffic.
module tb_alu_exec_unit;
  localparam int WIDTH = 5;
  localparam int AW    = 2;
  localparam int MOD   = 1 << WIDTH;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_exec_unit_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

  alu_exec_unit #(.WIDTH(WIDTH), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_pass  = 0;
  int n_total = 0;
  bit cmp_on  = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference arithmetic, straight from the opcode definitions.
  function automatic void model_eval(input int op, input int a, input int b,
                                     output int d, output int c, output int z);
    int full;
    c = 0;
    z = 0;
    d = 0;
    case (op)
      0: begin full = a + b; d = full % MOD; c = int'(full > MOD - 1); end
      1: begin d = (a - b) & (MOD - 1); c = int'(a < b); end
      2: d = a & b;
      3: d = a | b;
      4: d = a ^ b;
      5: begin full = a << (b & 7); d = full % MOD; c = int'((full / MOD) != 0); end
      6: begin full = a * b; d = full % MOD; c = int'(full > MOD - 1); end
      default: begin
        if (b == 0) begin d = MOD - 1; z = 1; end
        else d = a / b;
      end
    endcase
  endfunction

  // Model: countdown of busy cycles left; the write-back happens on the last one.
  int left = 0;
  int p_data, p_carry, p_dbz, p_addr;
  int e_data = 0, e_carry = 0, e_dbz = 0, e_addr = 0, e_zero = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      left = 0;
      e_data = 0; e_carry = 0; e_dbz = 0; e_addr = 0; e_zero = 0;
    end else begin
      if (left > 0) begin
        left--;
      end else if (bus.start) begin
        model_eval(int'(bus.op), int'(bus.a), int'(bus.b), p_data, p_carry, p_dbz);
        p_addr = int'(bus.dst);
        left   = (int'(bus.op) >= 6) ? WIDTH + 1 : 1;
      end
      if (left == 1) begin
        e_data  = p_data;
        e_carry = p_carry;
        e_dbz   = p_dbz;
        e_addr  = p_addr;
        e_zero  = int'(p_data == 0);
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("busy",    int'(bus.busy),        int'(left > 0));
      chk("wb_en",   int'(bus.wb_en),       int'(left == 1));
      chk("wb_addr", int'(bus.wb_addr),     e_addr);
      chk("wb_data", int'(bus.wb_data),     e_data);
      chk("zero",    int'(bus.zero),        e_zero);
      chk("carry",   int'(bus.carry),       e_carry);
      chk("dbz",     int'(bus.div_by_zero), e_dbz);
    end
  end

  task automatic drive(input int st, input int op, input int a, input int b, input int dst);
    bus.start = st[0];
    bus.op    = 3'(op);
    bus.a     = WIDTH'(a);
    bus.b     = WIDTH'(b);
    bus.dst   = AW'(dst);
  endtask

  task automatic run_op(input string tag, input int op, input int a, input int b, input int dst,
                        input int exp_lat, input int exp_data, input int exp_carry,
                        input int exp_zero, input int exp_dbz);
    int lat;
    bit seen;
    @(negedge clk);
    drive(1, op, a, b, dst);
    @(negedge clk);
    drive(0, int'($urandom_range(0, 7)), int'($urandom_range(0, 31)),
          int'($urandom_range(0, 31)), int'($urandom_range(0, 3)));
    chk({tag, "_busy_first"}, int'(bus.busy), 1);
    lat  = 1;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (bus.wb_en) seen = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    chk({tag, "_wb_seen"}, int'(seen), 1);
    if (seen) begin
      chk({tag, "_latency"}, lat, exp_lat);
      chk({tag, "_addr"},    int'(bus.wb_addr), dst);
      chk({tag, "_data"},    int'(bus.wb_data), exp_data);
      chk({tag, "_carry"},   int'(bus.carry), exp_carry);
      chk({tag, "_zero"},    int'(bus.zero), exp_zero);
      chk({tag, "_dbz"},     int'(bus.div_by_zero), exp_dbz);
    end
    @(negedge clk);
    chk({tag, "_idle_after"}, int'(bus.busy), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int wb_cnt, wb_pos;
    drive(0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    cmp_on = 1'b1;
    @(negedge clk);
    chk("reset_busy",  int'(bus.busy), 0);
    chk("reset_wb_en", int'(bus.wb_en), 0);
    chk("reset_data",  int'(bus.wb_data), 0);
    chk("reset_flags", int'({bus.zero, bus.carry, bus.div_by_zero}), 0);
    rst_n = 1'b1;

    run_op("add_7_6",   0,  7,  6, 0, 1, 13, 0, 0, 0);
    run_op("add_20_15", 0, 20, 15, 1, 1,  3, 1, 0, 0);
    run_op("sub_6_7",   1,  6,  7, 2, 1, 31, 1, 0, 0);
    run_op("xor_5_5",   4,  5,  5, 3, 1,  0, 0, 1, 0);
    run_op("and_12_10", 2, 12, 10, 1, 1,  8, 0, 0, 0);
    run_op("shl_3_3",   5,  3,  3, 0, 1, 24, 0, 0, 0);
    run_op("shl_12_2",  5, 12,  2, 0, 1, 16, 1, 0, 0);
    run_op("shl_1_7",   5,  1,  7, 2, 1,  0, 1, 1, 0);
    run_op("mul_7_6",   6,  7,  6, 2, 6, 10, 1, 0, 0);
    run_op("mul_3_5",   6,  3,  5, 1, 6, 15, 0, 0, 0);
    run_op("div_23_4",  7, 23,  4, 3, 6,  5, 0, 0, 0);
    run_op("div_9_0",   7,  9,  0, 1, 6, 31, 0, 0, 1);
    run_op("add_clr",   0,  7,  6, 0, 1, 13, 0, 0, 0);

    // Starts pulsed mid-MUL and during its write-back must be dropped.
    @(negedge clk);
    drive(1, 6, 7, 6, 2);
    wb_cnt = 0;
    wb_pos = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      drive(int'(k == 2 || k == 6), 0, 1, 1, 3);
      if (bus.wb_en) begin
        wb_cnt++;
        wb_pos = k;
        chk("ignore_data", int'(bus.wb_data), 10);
      end
    end
    drive(0, 0, 0, 0, 0);
    chk("ignore_wb_count", wb_cnt, 1);
    chk("ignore_wb_pos",   wb_pos, 6);

    // Reset in the middle of a MUL: no write-back, outputs cleared.
    @(negedge clk);
    drive(1, 6, 7, 6, 2);
    wb_cnt = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      drive(0, 0, 0, 0, 0);
      if (k == 3) rst_n = 1'b0;
      if (k == 4) begin
        chk("rst_mid_busy",  int'(bus.busy), 0);
        chk("rst_mid_data",  int'(bus.wb_data), 0);
        chk("rst_mid_addr",  int'(bus.wb_addr), 0);
        chk("rst_mid_flags", int'({bus.zero, bus.carry, bus.div_by_zero}), 0);
        rst_n = 1'b1;
      end
      if (bus.wb_en) wb_cnt++;
    end
    chk("rst_mid_no_wb", wb_cnt, 0);
    run_op("add_post_rst", 0, 7, 6, 0, 1, 13, 0, 0, 0);

    // Random traffic, including starts while busy, b==0 and occasional resets.
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 199) != 0);
      drive(int'($urandom_range(0, 2) == 0), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 31)),
            ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 31)),
            int'($urandom_range(0, 3)));
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0);
    repeat (10) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
